// File: rtl/mux2x1_structural_if.sv
// Bundle of the mux data/select signals and its observation outputs.
// The driver side owns a/b/sel; the mux side owns out/out_q/sel_cnt.
interface mux2x1_structural_if #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sel;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] out_q;
    logic [CNT_W-1:0] sel_cnt;

    modport master (
        output a, b, sel,
        input  out, out_q, sel_cnt
    );

    modport slave (
        input  a, b, sel,
        output out, out_q, sel_cnt
    );
endinterface

// File: rtl/mux2x1_structural.sv
// Gate-level 2:1 mux; out is combinational (0 cycles), out_q registers it (1 cycle).
// No backpressure; sel_cnt saturates rather than wrapping.
module mux2x1_structural #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    output wire  [WIDTH-1:0] out,
    input  wire  [WIDTH-1:0] a,
    input  wire  [WIDTH-1:0] b,
    input  wire              sel,
    input  wire              clk,
    input  wire              rst,
    output logic [WIDTH-1:0] out_q,
    output logic [CNT_W-1:0] sel_cnt
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    wire w_nsel;

    // Primitive gates only, so the select path stays free of reset and clock.
    not u_not_sel (w_nsel, sel);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            wire w_t0;
            wire w_t1;
            and u_and_a (w_t0, a[gi], w_nsel);
            and u_and_b (w_t1, b[gi], sel);
            or  u_or    (out[gi], w_t0, w_t1);
        end
    endgenerate

    logic [WIDTH-1:0] r_out_q;
    logic             r_sel_q;
    logic [CNT_W-1:0] r_sel_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_q   <= '0;
            r_sel_q   <= 1'b0;
            r_sel_cnt <= '0;
        end else begin
            r_out_q <= out;
            r_sel_q <= sel;
            if ((sel != r_sel_q) && (r_sel_cnt != CNT_MAX)) begin
                r_sel_cnt <= r_sel_cnt + CNT_ONE;
            end
        end
    end

    assign out_q   = r_out_q;
    assign sel_cnt = r_sel_cnt;
endmodule

// File: tb/tb_mux2x1_structural.sv
// Directed bench: exhaustive 1-bit truth table, 8-bit data/latency, reset,
// counting, saturation (3-bit counter) and reset colliding with a select change.
module tb_mux2x1_structural;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    mux2x1_structural_if #(.WIDTH(1), .CNT_W(8)) if1 ();
    mux2x1_structural_if #(.WIDTH(8), .CNT_W(8)) if8 ();
    mux2x1_structural_if #(.WIDTH(8), .CNT_W(3)) if3 ();

    mux2x1_structural #(.WIDTH(1), .CNT_W(8)) dut1 (
        .out(if1.out), .a(if1.a), .b(if1.b), .sel(if1.sel),
        .clk(clk), .rst(rst), .out_q(if1.out_q), .sel_cnt(if1.sel_cnt)
    );
    mux2x1_structural #(.WIDTH(8), .CNT_W(8)) dut8 (
        .out(if8.out), .a(if8.a), .b(if8.b), .sel(if8.sel),
        .clk(clk), .rst(rst), .out_q(if8.out_q), .sel_cnt(if8.sel_cnt)
    );
    mux2x1_structural #(.WIDTH(8), .CNT_W(3)) dut3 (
        .out(if3.out), .a(if3.a), .b(if3.b), .sel(if3.sel),
        .clk(clk), .rst(rst), .out_q(if3.out_q), .sel_cnt(if3.sel_cnt)
    );

    typedef struct {
        logic a;
        logic b;
        logic sel;
        logic exp_out;
    } vec_t;

    vec_t vecs [8];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Step past the next rising edge so sampling and driving stay off the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_cnt;

        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b1};

        if8.a = 8'hA5; if8.b = 8'h3C; if8.sel = 1'b1;
        if3.a = 8'h0F; if3.b = 8'hF0; if3.sel = 1'b0;

        for (int i = 0; i < 8; i++) begin
            if1.a   = vecs[i].a;
            if1.b   = vecs[i].b;
            if1.sel = vecs[i].sel;
            #10;
            chk($sformatf("sweep_out[%0d]", i), 32'(if1.out), 32'(vecs[i].exp_out));
        end

        // Reset held for two edges; out must keep following the inputs.
        rst = 1'b1;
        tick();
        tick();
        chk("rst_out_q", 32'(if8.out_q), 32'h0);
        chk("rst_sel_cnt", 32'(if8.sel_cnt), 32'h0);
        chk("rst_out_sel1", 32'(if8.out), 32'h3C);
        if8.sel = 1'b0;
        #1;
        chk("rst_out_sel0", 32'(if8.out), 32'hA5);
        tick();
        chk("rst_out_q_hold", 32'(if8.out_q), 32'h0);

        rst = 1'b0;
        tick();
        chk("q_a5", 32'(if8.out_q), 32'hA5);
        chk("cnt_idle", 32'(if8.sel_cnt), 32'h0);
        if8.sel = 1'b1;
        #1;
        chk("out_3c", 32'(if8.out), 32'h3C);
        chk("q_before_edge", 32'(if8.out_q), 32'hA5);
        tick();
        chk("q_3c", 32'(if8.out_q), 32'h3C);
        chk("cnt_first", 32'(if8.sel_cnt), 32'h1);

        for (int k = 0; k < 9; k++) begin
            if8.sel = ~if8.sel;
            tick();
        end
        chk("cnt_ten", 32'(if8.sel_cnt), 32'd10);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("cnt_hold[%0d]", k), 32'(if8.sel_cnt), 32'd10);
        end

        for (int k = 1; k <= 12; k++) begin
            if3.sel = ~if3.sel;
            tick();
            exp_cnt = (k > 7) ? 7 : k;
            chk($sformatf("sat_cnt[%0d]", k), 32'(if3.sel_cnt), 32'(exp_cnt));
        end
        tick();
        chk("sat_hold", 32'(if3.sel_cnt), 32'd7);

        // Build up to 5, then reset on the same edge as a select change.
        rst = 1'b1;
        if8.sel = 1'b0;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if8.sel = ~if8.sel;
            tick();
        end
        chk("mid_cnt5", 32'(if8.sel_cnt), 32'd5);
        rst = 1'b1;
        if8.sel = 1'b0;
        tick();
        chk("mid_rst_cnt", 32'(if8.sel_cnt), 32'h0);
        chk("mid_rst_q", 32'(if8.out_q), 32'h0);
        chk("mid_rst_out", 32'(if8.out), 32'hA5);
        rst = 1'b0;
        if8.sel = 1'b1;
        tick();
        chk("resume_cnt", 32'(if8.sel_cnt), 32'h1);
        chk("resume_q", 32'(if8.out_q), 32'h3C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
